com_read_parse: RTL and testbench

- Byte-stream frame parser directly upstream of the console controller.
- Consumes raw received bytes from the link PHY/UART and hunts for the frame header.
- Validates the bag type, length and checksum, and stores the payload in a local buffer.
- Presents the bag type to the console through the fs/fd four-phase handshake: `fs_com_read`, `fd_com_read`, `com_read_btype`.

---
 rtl/com_pkg.sv | 45 ++++
 rtl/com_read_buf.sv | 32 +++
 rtl/com_read_parse.sv | 175 +++++++++++++++++
 tb/tb_com_read_parse.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
//------------------------------------------------------------------------------
// com_pkg
// Shared constants for the console read path: bag type codes, the TYPE marker
// nibble, default frame header bytes and the frame parser state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package com_pkg;

  // Legal bag type codes carried in TYPE[3:0]
  localparam logic [3:0] BAG_LINK  = 4'h1;
  localparam logic [3:0] BAG_CONF  = 4'h5;
  localparam logic [3:0] BAG_WORK  = 4'h9;
  localparam logic [3:0] BAG_STOP  = 4'hD;

  // Required value of TYPE[7:4]
  localparam logic [3:0] TYPE_MARK = 4'h5;

  // Default frame header bytes
  localparam logic [7:0] HEAD0_DEF = 8'h55;
  localparam logic [7:0] HEAD1_DEF = 8'hAA;

  // Frame parser states
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_HDR  = 4'd1,
    ST_TYPE = 4'd2,
    ST_LEN  = 4'd3,
    ST_DATA = 4'd4,
    ST_CSUM = 4'd5,
    ST_ERR  = 4'd6,
    ST_DONE = 4'd7,
    ST_WAIT = 4'd8
  } state_t;

  // True when the low nibble of TYPE is one of the defined bag codes
  function automatic logic is_bag(input logic [3:0] code);
    return (code == BAG_LINK) || (code == BAG_CONF) ||
           (code == BAG_WORK) || (code == BAG_STOP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/com_read_buf.sv
//------------------------------------------------------------------------------
// com_read_buf
// BUF_DEPTH x 8 payload register file: synchronous write, asynchronous read.
// Contents are not reset.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module com_read_buf #(
  parameter int BUF_DEPTH = 16,
  parameter int AW        = $clog2(BUF_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [BUF_DEPTH];

  // Payload byte write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/com_read_parse.sv
//------------------------------------------------------------------------------
// com_read_parse
// Byte-stream frame parser: hunts for HEAD0/HEAD1, validates TYPE, LEN and the
// XOR checksum, buffers the payload and offers the frame to the console over
// the fs/fd four-phase handshake.
// Optional feature macro: COM_READ_TIMEOUT_EN (inter-byte timeout -> ERR).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module com_read_parse
  import com_pkg::*;
#(
  parameter int         BUF_DEPTH = 16,
  parameter logic [7:0] HEAD0     = HEAD0_DEF,
  parameter logic [7:0] HEAD1     = HEAD1_DEF,
  parameter int         TIMEOUT   = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_vld,
  output logic                         fs_com_read,
  input  logic                         fd_com_read,
  output logic [3:0]                   com_read_btype,
  output logic [7:0]                   com_read_len,
  input  logic [$clog2(BUF_DEPTH)-1:0] rd_addr,
  output logic [7:0]                   rd_data,
  output logic [7:0]                   err_cnt,
  output logic [7:0]                   drop_cnt
);

  localparam int         AW      = $clog2(BUF_DEPTH);
  localparam logic [7:0] MAX_LEN = 8'(BUF_DEPTH);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] csum_acc;
  logic [7:0] len_lat;
  logic [7:0] idx;
  logic [3:0] btype_lat;
  logic       buf_we;
  logic       timeout;
  logic       type_ok;
  logic       csum_ok;
  logic       last_data;

  assign type_ok   = (rx_data[7:4] == TYPE_MARK) && is_bag(rx_data[3:0]);
  assign csum_ok   = (rx_data == csum_acc);
  assign last_data = ((idx + 8'd1) == len_lat);

`ifdef COM_READ_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        parsing;

  assign parsing = (state == ST_HDR) || (state == ST_TYPE) || (state == ST_LEN) ||
                   (state == ST_DATA) || (state == ST_CSUM);

  // Inter-byte idle counter, only live while a frame is partially received
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  tmo_cnt <= '0;
    else if (!parsing || rx_vld) tmo_cnt <= '0;
    else                       tmo_cnt <= tmo_cnt + 32'd1;
  end

  assign timeout = parsing && !rx_vld && (tmo_cnt == 32'(TIMEOUT - 1));
`else
  // Feature compiled out: a partial frame waits indefinitely
  assign timeout = 1'b0 & (TIMEOUT == 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a timeout overrides any hold in a parsing state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rx_vld && rx_data == HEAD0) state_nxt = ST_HDR;
      ST_HDR: begin
        if (rx_vld) begin
          if (rx_data == HEAD1)      state_nxt = ST_TYPE;
          else if (rx_data == HEAD0) state_nxt = ST_HDR;
          else                       state_nxt = ST_IDLE;
        end
      end
      ST_TYPE: if (rx_vld) state_nxt = type_ok ? ST_LEN : ST_ERR;
      ST_LEN: begin
        if (rx_vld) begin
          if (rx_data > MAX_LEN)     state_nxt = ST_ERR;
          else if (rx_data == 8'd0)  state_nxt = ST_CSUM;
          else                       state_nxt = ST_DATA;
        end
      end
      ST_DATA: if (rx_vld && last_data) state_nxt = ST_CSUM;
      ST_CSUM: if (rx_vld) state_nxt = csum_ok ? ST_DONE : ST_ERR;
      ST_ERR:  state_nxt = ST_IDLE;
      ST_DONE: if (fd_com_read)  state_nxt = ST_WAIT;
      ST_WAIT: if (!fd_com_read) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout) state_nxt = ST_ERR;
  end

  // State-decoded outputs
  always_comb begin
    fs_com_read = (state == ST_DONE);
    buf_we      = (state == ST_DATA) && rx_vld;
  end

  // Frame datapath: type/length latches, running checksum, payload index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_acc       <= '0;
      len_lat        <= '0;
      idx            <= '0;
      btype_lat      <= '0;
      com_read_btype <= '0;
      com_read_len   <= '0;
    end else if (rx_vld) begin
      case (state)
        ST_TYPE: begin
          btype_lat <= rx_data[3:0];
          csum_acc  <= rx_data;
        end
        ST_LEN: begin
          csum_acc <= csum_acc ^ rx_data;
          len_lat  <= rx_data;
          idx      <= '0;
        end
        ST_DATA: begin
          csum_acc <= csum_acc ^ rx_data;
          idx      <= idx + 8'd1;
        end
        ST_CSUM: begin
          if (csum_ok) begin
            com_read_btype <= btype_lat;
            com_read_len   <= len_lat;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating counters for rejected frames and bytes dropped in the handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == ST_ERR && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (rx_vld && (state == ST_DONE || state == ST_WAIT) && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  com_read_buf #(
    .BUF_DEPTH (BUF_DEPTH),
    .AW        (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_com_read_parse.sv
//------------------------------------------------------------------------------
// tb_com_read_parse
// Scoreboard bench: stimulus pushes the expected frame for every good frame it
// sends; a console-side monitor pops and compares whenever fs_com_read rises,
// then completes the fs/fd handshake.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_com_read_parse;

  localparam int BUF_DEPTH = 16;
  localparam int TIMEOUT   = 100;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed {
    logic [3:0]       btype;
    logic [7:0]       len;
    logic [15:0][7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_vld = 1'b0;
  logic       fd_com_read = 1'b0;
  logic [3:0] rd_addr = 4'h0;
  logic       fs_com_read;
  logic [3:0] com_read_btype;
  logic [7:0] com_read_len;
  logic [7:0] rd_data;
  logic [7:0] err_cnt;
  logic [7:0] drop_cnt;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  bit     hold_fd = 1'b0;
  bit     mon_busy = 1'b0;
  logic   mon_prev = 1'b0;
  bytes_t fr;
  bytes_t pl;

  com_read_parse #(
    .BUF_DEPTH (BUF_DEPTH),
    .HEAD0     (8'h55),
    .HEAD1     (8'hAA),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_vld         (rx_vld),
    .fs_com_read    (fs_com_read),
    .fd_com_read    (fd_com_read),
    .com_read_btype (com_read_btype),
    .com_read_len   (com_read_len),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .err_cnt        (err_cnt),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive bytes back-to-back, one per cycle, changing inputs on the falling edge
  task automatic send_bytes(input bytes_t b);
    foreach (b[i]) begin
      @(negedge clk);
      rx_data = b[i];
      rx_vld  = 1'b1;
    end
    @(negedge clk);
    rx_vld  = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic push_exp(input logic [3:0] bt, input logic [7:0] ln, input bytes_t d);
    exp_t e;
    e = '0;
    e.btype = bt;
    e.len   = ln;
    foreach (d[i]) e.data[i] = d[i];
    sb.push_back(e);
  endtask

  // Let the DUT settle, then wait until every expected frame has been consumed
  task automatic wait_idle();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && !mon_busy) return;
      @(negedge clk);
    end
    check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Console-side monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && fs_com_read && !mon_prev) begin
        mon_busy = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          for (int k = 0; k < 5000 && hold_fd; k++) @(negedge clk);
          if (hold_fd) check("hold_timeout", 32'd1, 32'd0);
          check("btype", 32'(com_read_btype), 32'(e.btype));
          check("len", 32'(com_read_len), 32'(e.len));
          for (int i = 0; i < int'(e.len); i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(e.data[i]));
          end
        end
        fd_com_read = 1'b1;
        @(negedge clk);
        check("fs_drop_after_fd", 32'(fs_com_read), 32'd0);
        fd_com_read = 1'b0;
        @(negedge clk);
        mon_busy = 1'b0;
      end
      mon_prev = fs_com_read;
    end
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check("rst_fs", 32'(fs_com_read), 32'd0);
    check("rst_btype", 32'(com_read_btype), 32'd0);
    check("rst_len", 32'(com_read_len), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // LINK, zero-length payload; fs one cycle after the checksum byte
    pl = {};
    push_exp(4'h1, 8'd0, pl);
    fr = {8'h55, 8'hAA, 8'h51, 8'h00, 8'h51};
    send_bytes(fr);
    check("fs_after_csum", 32'(fs_com_read), 32'd1);
    wait_idle();

    // CONF, 3 bytes; checksum 55^03^11^22^33 = 0x56
    pl = {8'h11, 8'h22, 8'h33};
    push_exp(4'h5, 8'd3, pl);
    fr = {8'h55, 8'hAA, 8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h56};
    send_bytes(fr);
    wait_idle();

    // Bad checksum (correct value 0x57) -> rejected
    fr = {8'h55, 8'hAA, 8'h59, 8'h01, 8'h0F, 8'h00};
    send_bytes(fr);
    check("bad_csum_no_fs", 32'(fs_com_read), 32'd0);
    wait_idle();
    check("err_bad_csum", 32'(err_cnt), 32'd1);

    // STOP, 2 bytes, checksum 5D^02^A5^5A = 0xA0
    pl = {8'hA5, 8'h5A};
    push_exp(4'hD, 8'd2, pl);
    fr = {8'h55, 8'hAA, 8'h5D, 8'h02, 8'hA5, 8'h5A, 8'hA0};
    send_bytes(fr);
    wait_idle();
    check("err_after_good", 32'(err_cnt), 32'd1);

    // Illegal btype, then LEN=17 over the buffer depth
    fr = {8'h55, 8'hAA, 8'h53, 8'h00, 8'h53};
    send_bytes(fr);
    wait_idle();
    check("err_bad_type", 32'(err_cnt), 32'd2);
    fr = {8'h55, 8'hAA, 8'h55, 8'h11};
    send_bytes(fr);
    wait_idle();
    check("err_len_17", 32'(err_cnt), 32'd3);

    // Noise, HEAD0 repeated (resync), WORK with 1 byte; checksum 59^01^3C = 0x64
    pl = {8'h3C};
    push_exp(4'h9, 8'd1, pl);
    fr = {8'h12, 8'h55, 8'h55, 8'hAA, 8'h59, 8'h01, 8'h3C, 8'h64};
    send_bytes(fr);
    wait_idle();

    // Maximum length 16: bytes k*0x11 XOR to 0, so checksum 55^10 = 0x45
    pl = {};
    fr = {8'h55, 8'hAA, 8'h55, 8'h10};
    for (int k = 0; k < 16; k++) begin
      pl.push_back(8'(k * 17));
      fr.push_back(8'(k * 17));
    end
    fr.push_back(8'h45);
    push_exp(4'h5, 8'd16, pl);
    send_bytes(fr);
    wait_idle();
    check("err_after_max", 32'(err_cnt), 32'd3);

    // Bytes arriving while the console holds the frame are dropped
    hold_fd = 1'b1;
    pl = {8'hC3, 8'h3C};
    push_exp(4'h9, 8'd2, pl);
    fr = {8'h55, 8'hAA, 8'h59, 8'h02, 8'hC3, 8'h3C, 8'hA4};
    send_bytes(fr);
    check("fs_held", 32'(fs_com_read), 32'd1);
    fr = {8'h55, 8'hAA, 8'h51};
    send_bytes(fr);
    check("drop_cnt_3", 32'(drop_cnt), 32'd3);
    check("btype_held", 32'(com_read_btype), 32'h9);
    check("len_held", 32'(com_read_len), 32'd2);
    hold_fd = 1'b0;
    wait_idle();
    check("err_after_drop", 32'(err_cnt), 32'd3);

    // Asynchronous reset in the middle of a payload
    fr = {8'h55, 8'hAA, 8'h55, 8'h03, 8'h11};
    send_bytes(fr);
    rst = 1'b0;
    #1;
    check("mid_rst_fs", 32'(fs_com_read), 32'd0);
    check("mid_rst_btype", 32'(com_read_btype), 32'd0);
    check("mid_rst_len", 32'(com_read_len), 32'd0);
    check("mid_rst_err", 32'(err_cnt), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pl = {};
    push_exp(4'h1, 8'd0, pl);
    fr = {8'h55, 8'hAA, 8'h51, 8'h00, 8'h51};
    send_bytes(fr);
    wait_idle();
    check("err_after_rst", 32'(err_cnt), 32'd0);

`ifdef COM_READ_TIMEOUT_EN
    // Stall after TYPE for longer than TIMEOUT
    fr = {8'h55, 8'hAA, 8'h55};
    send_bytes(fr);
    repeat (TIMEOUT + 10) @(negedge clk);
    check("err_timeout", 32'(err_cnt), 32'd1);
    check("fs_timeout", 32'(fs_com_read), 32'd0);
    pl = {8'h11, 8'h22, 8'h33};
    push_exp(4'h5, 8'd3, pl);
    fr = {8'h55, 8'hAA, 8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h56};
    send_bytes(fr);
    wait_idle();
    check("err_after_timeout", 32'(err_cnt), 32'd1);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
